// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO with registered-pointer full/empty flags.
// Optional occupancy count and sticky overflow/underflow flags: define SYNC_FIFO_COUNT_EN.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
`ifdef SYNC_FIFO_COUNT_EN
    ,
    output logic [PTR_W:0]        data_count,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]        wr_ptr_r;
    logic [PTR_W:0]        rd_ptr_r;
    logic                  write_ok_s;
    logic                  read_ok_s;
    logic                  empty_s;
    logic                  full_s;

    // Flags decode from registered pointers only; the MSB is the wrap bit.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]) &&
                  (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]);
    end

    // Request acceptance using the flags as they stand before the edge.
    always_comb begin
        write_ok_s = w_en & ~full_s;
        read_ok_s  = r_en & ~empty_s;
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (write_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (read_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are left uncleared since empty masks them.
    always_ff @(posedge clk) begin
        if (write_ok_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= data_in;
        end
    end

    // Head of queue, forced to zero while empty so stale/X data never escapes.
    always_comb begin
        if (empty_s) begin
            data_out = {DATA_WIDTH{1'b0}};
        end else begin
            data_out = mem_r[rd_ptr_r[PTR_W-1:0]];
        end
        full  = full_s;
        empty = empty_s;
    end

`ifdef SYNC_FIFO_COUNT_EN
    assign data_count = wr_ptr_r - rd_ptr_r;

    // Sticky misuse flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full_s) begin
                overflow <= 1'b1;
            end
            if (r_en && empty_s) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    // Plain FIFO: no occupancy or misuse outputs.
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH 8, DATA_WIDTH 8).
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic       w_en;
    logic       r_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
`ifdef SYNC_FIFO_COUNT_EN
    logic [3:0] data_count;
    logic       overflow;
    logic       underflow;
`endif

    int checks;
    int errors;

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef SYNC_FIFO_COUNT_EN
        ,
        .data_count (data_count),
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
        repeat (10) tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", data_out); end
        rst = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty got %b want 1", empty); end
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (data_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", data_count); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b%b want 00", overflow, underflow); end
`endif
    endtask

    task automatic test_single_word();
        w_en = 1'b1; data_in = 8'hA5;
        tick();
        w_en = 1'b0;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", empty); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_dout got %h want a5", data_out); end
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_drain_empty got %b want 1", empty); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL single_drain_dout got %h want 00", data_out); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            w_en = 1'b1; data_in = 8'(i);
            tick();
            checks++;
            if (full !== (i == 8)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 8)); end
        end
        data_in = 8'hFF;
        tick();
        w_en = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_drop_full got %b want 1", full); end
        checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL fill_drop_head got %h want 01", data_out); end
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow got %b want 1", overflow); end
        checks++; if (data_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", data_count); end
`endif
        r_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (data_out !== 8'(i)) begin errors++; $display("FAIL fill_read[%0d] got %h want %h", i, data_out, 8'(i)); end
            tick();
        end
        r_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_end_empty got %b want 1", empty); end
    endtask

    task automatic test_underflow();
        r_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (empty !== 1'b1 || data_out !== 8'h00) begin errors++; $display("FAIL underflow_idle[%0d] got e=%b d=%h want e=1 d=00", i, empty, data_out); end
        end
        r_en = 1'b0;
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag got %b want 1", underflow); end
`endif
        // If rd_ptr had moved, the next written word would not be the head.
        w_en = 1'b1; data_in = 8'h3C;
        tick();
        w_en = 1'b0;
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL underflow_ptr got %h want 3c", data_out); end
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
    endtask

    task automatic test_simul_half();
        logic [7:0] q[$];
        for (int i = 0; i < 4; i++) begin
            w_en = 1'b1; data_in = 8'h10 + 8'(i); q.push_back(data_in);
            tick();
        end
        r_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = 8'h40 + 8'(i);
            checks++;
            if (data_out !== q[0]) begin errors++; $display("FAIL half_rw[%0d] got %h want %h", i, data_out, q[0]); end
            tick();
            void'(q.pop_front());
            q.push_back(data_in);
            checks++;
            if (full !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL half_flags[%0d] got f=%b e=%b want 0 0", i, full, empty); end
`ifdef SYNC_FIFO_COUNT_EN
            checks++;
            if (data_count !== 4'd4) begin errors++; $display("FAIL half_count[%0d] got %0d want 4", i, data_count); end
`endif
        end
        w_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out !== 8'h50 + 8'(i)) begin errors++; $display("FAIL half_drain[%0d] got %h want %h", i, data_out, 8'h50 + 8'(i)); end
            tick();
        end
        r_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL half_end_empty got %b want 1", empty); end
    endtask

    task automatic test_simul_full();
        w_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'h30 + 8'(i);
            tick();
        end
        r_en = 1'b1; data_in = 8'hEE;
        tick();
        w_en = 1'b0;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_rw_full got %b want 0", full); end
        checks++; if (data_out !== 8'h31) begin errors++; $display("FAIL full_rw_head got %h want 31", data_out); end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (data_out !== 8'h30 + 8'(i)) begin errors++; $display("FAIL full_rw_drain[%0d] got %h want %h", i, data_out, 8'h30 + 8'(i)); end
            tick();
        end
        r_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_rw_dropped got e=%b d=%h want e=1", empty, data_out); end
    endtask

    task automatic test_simul_empty();
        w_en = 1'b1; r_en = 1'b1; data_in = 8'h5A;
        tick();
        w_en = 1'b0;
        checks++; if (empty !== 1'b0 || data_out !== 8'h5A) begin errors++; $display("FAIL empty_rw got e=%b d=%h want e=0 d=5a", empty, data_out); end
        tick();
        r_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_rw_drain got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        w_en = 1'b1; data_in = 8'h77;
        tick(); tick();
        w_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL mid_reset got e=%b f=%b d=%h want 1 0 00", empty, full, data_out); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_reset_release got %b want 1", empty); end
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL mid_reset_sticky got %b%b want 00", overflow, underflow); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        for (int i = 0; i < 60; i++) begin
            w_en = (i % 2 == 0) || ($urandom_range(0, 3) == 0);
            r_en = (i % 2 == 1) || ($urandom_range(0, 3) == 0);
            data_in = 8'($urandom);
            #1;
            checks++;
            if (empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_empty[%0d] got %b want %b", i, empty, (q.size() == 0)); end
            if (r_en && q.size() > 0) begin
                checks++;
                if (data_out !== q[0]) begin errors++; $display("FAIL rand_pop[%0d] got %h want %h", i, data_out, q[0]); end
            end
            if (w_en && q.size() < 8) q.push_back(data_in);
            if (r_en && q.size() > 0 && !(w_en && q.size() == 1 && empty)) void'(q.pop_front());
            tick();
        end
        w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_word();
        test_fill();
        test_underflow();
        test_simul_half();
        test_simul_full();
        test_simul_empty();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
